pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Pipeline sequencer between DE and AGEX. Keeps a per-register scoreboard of in-flight writes.
//  Decides each cycle whether the instruction in DE issues to AGEX or stalls.
//  On a taken branch/jump resolved in AGEX (br_cond), it flushes FE/DE and squashes the wrong path.
//  Also keeps stall and flush performance counters.
// PARAMETERS
//  NREGS      32  architectural registers; x0 is never tracked
//  REGNOBITS  5   register index width, log2(NREGS)
//  CNTBITS    2   scoreboard counter width; max in-flight writes per reg = 2**CNTBITS-1
//  PERFBITS   32  width of the performance counters
// PORTS
//  clk            in   1          clock, rising edge
//  reset          in   1          synchronous, active-high
//  de_valid       in   1          DE holds a valid decoded instruction
//  de_rs1         in   REGNOBITS  source 1 index
//  de_rs1_used    in   1          instruction reads rs1
//  de_rs2         in   REGNOBITS  source 2 index
//  de_rs2_used    in   1          instruction reads rs2
//  de_rd          in   REGNOBITS  destination index
//  de_wr_reg      in   1          instruction writes rd
//  agex_valid     in   1          AGEX holds a valid instruction
//  agex_br_taken  in   1          AGEX branch condition true (taken BEQ..BGEU, JAL, JALR)
//  wb_valid       in   1          WB retires an instruction this cycle
//  wb_rd          in   REGNOBITS  retiring destination
//  wb_wr_reg      in   1          retiring instruction writes rd
//  issue_de       out  1          DE instruction advances to AGEX at this edge
//  stall_de       out  1          hold the FE and DE latches
//  flush_fe       out  1          redirect FE to the AGEX target; discard the fetched instruction
//  flush_de       out  1          load a bubble (all zeros) into the DE->AGEX latch
//  busy_vec       out  NREGS      bit r = scoreboard count[r] != 0; bit 0 always 0
//  sb_err         out  1          sticky: a decrement was seen with count already at 0
//  stall_cycles   out  PERFBITS   number of cycles with stall_de=1; wraps
//  flush_events   out  PERFBITS   number of taken-branch redirects; wraps
// BEHAVIOUR
//  Reset (sync): every count[r]=0, state=RUN, sb_err=0, both perf counters=0.
//   With idle inputs all combinational outputs are 0.
//  Reset applied mid-operation discards all in-flight tracking and any pending REDIRECT.
//  Scoreboard retire terms:
//   dec[r] = wb_valid & wb_wr_reg & (wb_rd==r) & (r!=0)
//   eff[r] = count[r] - dec[r], saturating at 0 (same-cycle WB bypass)
//  Hazard terms:
//   raw   = (de_rs1_used & rs1!=0 & eff[rs1]!=0) | (de_rs2_used & rs2!=0 & eff[rs2]!=0)
//   sat   = de_wr_reg & de_rd!=0 & eff[de_rd]==2**CNTBITS-1
//   flush = (state==RUN & agex_valid & agex_br_taken) | state==REDIRECT
//  Issue/stall, combinational, same cycle:
//   issue_de = de_valid & ~raw & ~sat & ~flush
//   stall_de = de_valid & (raw|sat) & ~flush  (flush always wins over stall)
//   flush_fe = flush_de = flush
//  Scoreboard update at each edge:
//   count[r] += (issue_de & de_wr_reg & de_rd==r & r!=0), and -= dec[r]
//   issue and retire to the same reg in the same cycle leave the count unchanged
//   a decrement at count 0 holds the count at 0 and sets sb_err
//  FSM: RUN -> REDIRECT when agex_valid & agex_br_taken. REDIRECT -> RUN unconditionally after 1 cycle.
//   The REDIRECT cycle squashes the wrong-path instruction fetched during the redirect cycle.
//   agex_br_taken is ignored while in REDIRECT, because AGEX then holds a bubble.
//  Flushed DE instructions never increment the scoreboard.
//  Performance counters: stall_cycles += stall_de; flush_events += (RUN & agex_valid & agex_br_taken).
//   Both wrap modulo 2**PERFBITS.
//  Latency: hazard detection is 0 cycles. An rd issued at edge N clears at the edge where WB retires it.
// TESTING
//  1. Issue add x5, then add x6,x5,x5 next cycle -> stall_de=1 until wb retires x5; issue_de=1 in the retire cycle.
//  2. rs1=x0 with count irrelevant, de_rs1_used=1 -> no stall; writes to x0 never change busy_vec.
//  3. agex_br_taken=1 while DE has a RAW hazard -> stall_de=0, flush_fe=flush_de=1 for 2 cycles, flush_events=1.
//  4. Three back-to-back writes to x7 (CNTBITS=2) -> count=3, 4th write stalls (sat); WB x7 retire same cycle lets it issue.
//  5. wb retire of x9 with count[x9]=0 -> count stays 0, sb_err=1 until reset.
//  6. Assert reset with busy_vec=0x0000_00A0 and state REDIRECT -> next cycle busy_vec=0, no flush, counters=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - DE/AGEX issue sequencer with register scoreboard and branch flush
//
// Purpose:
//   Tracks in-flight register writes with a per-register counter and decides each
//   cycle whether the DE instruction issues to AGEX or stalls. A taken branch in
//   AGEX flushes FE/DE for two cycles (the resolve cycle plus one REDIRECT cycle).
//   Counts stall cycles and taken-branch redirects.
//
// Ports:
//   clk, reset                   clock (rising edge), synchronous active-high reset
//   de_*                         decoded instruction in DE (sources, destination, valid)
//   agex_valid, agex_br_taken    branch resolution in AGEX
//   wb_valid, wb_rd, wb_wr_reg   retiring instruction in WB
//   issue_de, stall_de           DE advance / hold FE+DE latches
//   flush_fe, flush_de           redirect FE / bubble into DE->AGEX latch
//   busy_vec                     per-register "write in flight" flags (bit 0 always 0)
//   sb_err                       sticky scoreboard underflow flag
//   stall_cycles, flush_events   wrapping performance counters
module pipe_hazard_ctrl #(
  parameter int NREGS     = 32,
  parameter int REGNOBITS = 5,
  parameter int CNTBITS   = 2,
  parameter int PERFBITS  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 de_valid,
  input  logic [REGNOBITS-1:0] de_rs1,
  input  logic                 de_rs1_used,
  input  logic [REGNOBITS-1:0] de_rs2,
  input  logic                 de_rs2_used,
  input  logic [REGNOBITS-1:0] de_rd,
  input  logic                 de_wr_reg,
  input  logic                 agex_valid,
  input  logic                 agex_br_taken,
  input  logic                 wb_valid,
  input  logic [REGNOBITS-1:0] wb_rd,
  input  logic                 wb_wr_reg,
  output logic                 issue_de,
  output logic                 stall_de,
  output logic                 flush_fe,
  output logic                 flush_de,
  output logic [NREGS-1:0]     busy_vec,
  output logic                 sb_err,
  output logic [PERFBITS-1:0]  stall_cycles,
  output logic [PERFBITS-1:0]  flush_events
);

  localparam logic [CNTBITS-1:0] CNT_MAX = '1;

  typedef enum logic {RUN = 1'b0, REDIRECT = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [CNTBITS-1:0]   count_q [NREGS];
  logic [CNTBITS-1:0]   count_d [NREGS];
  logic [CNTBITS-1:0]   eff     [NREGS];
  logic [NREGS-1:0]     dec;
  logic [NREGS-1:0]     inc;
  logic                 sb_err_q, sb_err_d;
  logic [PERFBITS-1:0]  stall_cycles_q, stall_cycles_d;
  logic [PERFBITS-1:0]  flush_events_q, flush_events_d;
  logic                 raw, sat, take_br, flush;

  // Retire decrement and the WB-bypassed view of each counter, so an instruction
  // whose producer retires this very cycle does not wait an extra cycle.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      dec[r] = wb_valid & wb_wr_reg & (wb_rd == REGNOBITS'(r)) & (r != 0);
      eff[r] = (dec[r] && count_q[r] != '0) ? count_q[r] - CNTBITS'(1) : count_q[r];
    end
  end

  always_comb begin
    raw      = (de_rs1_used & (de_rs1 != '0) & (eff[de_rs1] != '0))
             | (de_rs2_used & (de_rs2 != '0) & (eff[de_rs2] != '0));
    sat      = de_wr_reg & (de_rd != '0) & (eff[de_rd] == CNT_MAX);
    // A bubble sits in AGEX during REDIRECT, so its branch flag is not trusted then.
    take_br  = (state_q == RUN) & agex_valid & agex_br_taken;
    flush    = take_br | (state_q == REDIRECT);
    issue_de = de_valid & ~raw & ~sat & ~flush;
    stall_de = de_valid & (raw | sat) & ~flush;
    flush_fe = flush;
    flush_de = flush;
  end

  always_comb begin
    sb_err_d = sb_err_q;
    for (int r = 0; r < NREGS; r++) begin
      inc[r]     = issue_de & de_wr_reg & (de_rd == REGNOBITS'(r)) & (r != 0);
      count_d[r] = count_q[r];
      if (inc[r] && !dec[r]) begin
        count_d[r] = count_q[r] + CNTBITS'(1);
      end else if (dec[r] && !inc[r] && count_q[r] != '0) begin
        count_d[r] = count_q[r] - CNTBITS'(1);
      end
      // Underflow holds the count at 0 and is remembered until reset.
      if (dec[r] && count_q[r] == '0) begin
        sb_err_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = RUN;
    if (take_br) begin
      state_d = REDIRECT;
    end
    stall_cycles_d = stall_cycles_q + PERFBITS'(stall_de);
    flush_events_d = flush_events_q + PERFBITS'(take_br);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      sb_err_q       <= 1'b0;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
      for (int r = 0; r < NREGS; r++) begin
        count_q[r] <= '0;
      end
    end else begin
      state_q        <= state_d;
      sb_err_q       <= sb_err_d;
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
      for (int r = 0; r < NREGS; r++) begin
        count_q[r] <= count_d[r];
      end
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int r = 1; r < NREGS; r++) begin
      busy_vec[r] = (count_q[r] != '0);
    end
  end

  assign sb_err       = sb_err_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;

endmodule
